dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-ported data memory. Shares the memory between the core load/store path (port C) and a DMA/debug master (port D). Checks each request for legality and alignment, and drives the memory's `write_enable`/`A`/`write_data`/`mask`. Returns a registered response one cycle after acceptance, and guarantees that port D is never starved.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_req_check.sv | 28 ++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared mask codes, request/response structs and mask legality helper
package dmem_pkg;

   localparam logic [2:0] MASK_B  = 3'b000;
   localparam logic [2:0] MASK_H  = 3'b001;
   localparam logic [2:0] MASK_W  = 3'b010;
   localparam logic [2:0] MASK_BU = 3'b100;
   localparam logic [2:0] MASK_HU = 3'b101;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  mask;
   } dmem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } dmem_rsp_t;

   // Unsigned sizes only make sense for loads; stores have no sign to extend.
   function automatic logic mask_legal(input logic we, input logic [2:0] mask);
      case (mask)
         MASK_B, MASK_H, MASK_W: return 1'b1;
         MASK_BU, MASK_HU:       return !we;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_req_check.sv
// rtl/dmem_req_check.sv - combinational legality check of one request (mask, alignment, range)
module dmem_req_check #(
   parameter int MEM_WORDS = 1024
) (
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [2:0]  mask,
   output logic        legal
);
   import dmem_pkg::*;

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

   logic aligned;
   logic in_range;

   always_comb begin
      aligned  = 1'b1;
      case (mask[1:0])
         2'b01:   aligned = !addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      in_range = ({1'b0, addr} < ADDR_LIMIT);
      legal    = mask_legal(we, mask) && aligned && in_range;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with anti-starvation for port D
module dmem_arbiter #(
   parameter int MAX_WAIT  = 4,
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_req_valid,
   output logic        c_req_ready,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [2:0]  c_mask,
   output logic        c_rsp_valid,
   output logic [31:0] c_rsp_rdata,
   output logic        c_rsp_err,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_mask,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_rdata,
   output logic        d_rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_mask,
   input  logic [31:0] mem_rd
);
   import dmem_pkg::*;

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   dmem_req_t  c_req;
   dmem_req_t  d_req;
   dmem_req_t  g_req;
   dmem_rsp_t  rsp_next;
   dmem_rsp_t  c_rsp_q;
   dmem_rsp_t  d_rsp_q;
   logic       c_rsp_valid_q;
   logic       d_rsp_valid_q;
   logic [3:0] wait_cnt;
   logic       d_win;
   logic       c_grant;
   logic       d_grant;
   logic       grant;
   logic       legal;

   always_comb begin
      c_req   = '{we: c_we, addr: c_addr, wdata: c_wdata, mask: c_mask};
      d_req   = '{we: d_we, addr: d_addr, wdata: d_wdata, mask: d_mask};
      d_win   = d_req_valid && (!c_req_valid || (wait_cnt == WAIT_MAX));
      d_grant = d_win && !rst;
      c_grant = c_req_valid && !d_win && !rst;
      grant   = c_grant || d_grant;
      // With no grant the memory still sees port C so its address path stays quiet.
      g_req   = d_grant ? d_req : c_req;
   end

   dmem_req_check #(.MEM_WORDS(MEM_WORDS)) u_req_check (
      .we    (g_req.we),
      .addr  (g_req.addr),
      .mask  (g_req.mask),
      .legal (legal)
   );

   assign c_req_ready = c_grant;
   assign d_req_ready = d_grant;
   assign mem_we      = grant && g_req.we && legal && !rst;
   assign mem_addr    = g_req.addr;
   assign mem_wdata   = g_req.wdata;
   assign mem_mask    = g_req.mask;

   always_comb begin
      rsp_next.err   = !legal;
      rsp_next.rdata = (legal && !g_req.we) ? mem_rd : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt      <= 4'd0;
         c_rsp_valid_q <= 1'b0;
         d_rsp_valid_q <= 1'b0;
         c_rsp_q       <= '0;
         d_rsp_q       <= '0;
      end else begin
         if (!d_req_valid || d_grant) begin
            wait_cnt <= 4'd0;
         end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
         c_rsp_valid_q <= c_grant;
         d_rsp_valid_q <= d_grant;
         c_rsp_q       <= c_grant ? rsp_next : '0;
         d_rsp_q       <= d_grant ? rsp_next : '0;
      end
   end

   // A reset arriving while a response is on the wire kills it immediately.
   assign c_rsp_valid = c_rsp_valid_q && !rst;
   assign c_rsp_rdata = rst ? 32'd0 : c_rsp_q.rdata;
   assign c_rsp_err   = c_rsp_q.err && !rst;
   assign d_rsp_valid = d_rsp_valid_q && !rst;
   assign d_rsp_rdata = rst ? 32'd0 : d_rsp_q.rdata;
   assign d_rsp_err   = d_rsp_q.err && !rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with memory and reference model
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int MAX_WAIT  = 4;
   localparam int MEM_WORDS = 1024;
   localparam int MEM_BYTES = 4 * MEM_WORDS;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req_valid, c_req_ready, c_we, c_rsp_valid, c_rsp_err;
   logic [31:0] c_addr, c_wdata, c_rsp_rdata;
   logic [2:0]  c_mask;
   logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
   logic [31:0] d_addr, d_wdata, d_rsp_rdata;
   logic [2:0]  d_mask;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rd;
   logic [2:0]  mem_mask;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .rst(rst),
      .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_we(c_we), .c_addr(c_addr),
      .c_wdata(c_wdata), .c_mask(c_mask), .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
      .c_rsp_err(c_rsp_err),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_mask(d_mask), .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
      .d_rsp_err(d_rsp_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
      .mem_rd(mem_rd)
   );

   logic [7:0] phys    [MEM_BYTES];
   logic [7:0] ref_mem [MEM_BYTES];

   int n_checks = 0;
   int n_errors = 0;

   // Byte/half/word extraction with optional sign extension, little-endian.
   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] m);
      int          nb;
      logic [31:0] v, keep;
      nb = 1 << m[1:0];
      v  = word >> (8 * int'(off));
      if (nb >= 4) return v;
      keep = (32'd1 << (8 * nb)) - 32'd1;
      v    = v & keep;
      if (!m[2] && v[8 * nb - 1]) v = v | ~keep;
      return v;
   endfunction

   // Data memory: combinational read, byte-lane write at the clock edge.
   logic [11:0] rd_base;
   always_comb begin
      rd_base = {mem_addr[11:2], 2'b00};
      mem_rd  = extract({phys[rd_base + 12'd3], phys[rd_base + 12'd2], phys[rd_base + 12'd1],
                         phys[rd_base]}, mem_addr[1:0], mem_mask);
   end

   always @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (i < (1 << mem_mask[1:0])) phys[mem_addr[11:0] + 12'(i)] <= mem_wdata[8*i +: 8];
         end
      end
   end

   // Reference model state
   int          m_wait = 0;
   bit          pc_v = 0, pd_v = 0, pc_err = 0, pd_err = 0;
   logic [31:0] pc_rdata = 0, pd_rdata = 0;

   // Observations
   bit          seen_c_ready = 0, seen_d_ready = 0, we_seen = 0;
   int          c_rsp_cnt = 0, d_rsp_cnt = 0;
   logic [31:0] last_c_rdata = 0, last_d_rdata = 0;
   bit          last_c_err = 0, last_d_err = 0;

   function automatic bit ref_legal(input logic we, input logic [31:0] a, input logic [2:0] m);
      int nb;
      bit mask_ok;
      nb      = 1 << m[1:0];
      mask_ok = we ? (m <= 3'd2) : (m <= 3'd2 || m == 3'd4 || m == 3'd5);
      return mask_ok && ((a % nb) == 0) && (a < MEM_BYTES);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] m);
      int base;
      base = int'(a) & ~3;
      return extract({ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]},
                     a[1:0], m);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock: check outputs at the falling edge, advance the model at the rising edge.
   task automatic tick();
      bit          eg_c, eg_d, e_we, lg, gwe;
      logic [31:0] ga, gw;
      logic [2:0]  gm;
      int          nb;
      @(negedge clk);
      eg_d = !rst && d_req_valid && (!c_req_valid || m_wait >= MAX_WAIT);
      eg_c = !rst && c_req_valid && !eg_d;
      gwe  = eg_d ? d_we   : c_we;
      ga   = eg_d ? d_addr : c_addr;
      gw   = eg_d ? d_wdata : c_wdata;
      gm   = eg_d ? d_mask : c_mask;
      lg   = ref_legal(gwe, ga, gm);
      e_we = (eg_c || eg_d) && gwe && lg;
      check_eq("c_req_ready", c_req_ready, eg_c);
      check_eq("d_req_ready", d_req_ready, eg_d);
      check_eq("mem_we", mem_we, e_we);
      if (eg_c || eg_d) begin
         check_eq("mem_addr", mem_addr, ga);
         check_eq("mem_mask", mem_mask, gm);
         if (e_we) check_eq("mem_wdata", mem_wdata, gw);
      end
      check_eq("c_rsp_valid", c_rsp_valid, !rst && pc_v);
      check_eq("d_rsp_valid", d_rsp_valid, !rst && pd_v);
      if (rst) begin
         check_eq("c_rsp_rdata_rst", c_rsp_rdata, 0);
         check_eq("d_rsp_err_rst", d_rsp_err, 0);
      end else begin
         if (pc_v) begin
            check_eq("c_rsp_rdata", c_rsp_rdata, pc_rdata);
            check_eq("c_rsp_err", c_rsp_err, pc_err);
         end
         if (pd_v) begin
            check_eq("d_rsp_rdata", d_rsp_rdata, pd_rdata);
            check_eq("d_rsp_err", d_rsp_err, pd_err);
         end
      end
      seen_c_ready = c_req_ready;
      seen_d_ready = d_req_ready;
      if (mem_we) we_seen = 1;
      if (c_rsp_valid) begin
         c_rsp_cnt++;
         last_c_rdata = c_rsp_rdata;
         last_c_err   = c_rsp_err;
      end
      if (d_rsp_valid) begin
         d_rsp_cnt++;
         last_d_rdata = d_rsp_rdata;
         last_d_err   = d_rsp_err;
      end
      @(posedge clk);
      pc_v     = eg_c;
      pd_v     = eg_d;
      pc_err   = !lg;
      pd_err   = !lg;
      pc_rdata = (lg && !gwe) ? ref_load(ga, gm) : 32'd0;
      pd_rdata = pc_rdata;
      if (e_we) begin
         nb = 1 << gm[1:0];
         for (int i = 0; i < nb && i < 4; i++) ref_mem[int'(ga) + i] = gw[8*i +: 8];
      end
      if (rst || !d_req_valid || eg_d) m_wait = 0;
      else if (m_wait < MAX_WAIT)      m_wait = m_wait + 1;
      #1;
   endtask

   task automatic idle(input int n);
      c_req_valid = 0;
      d_req_valid = 0;
      repeat (n) tick();
   endtask

   task automatic issue_c(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] m);
      c_req_valid = 1; c_we = we; c_addr = a; c_wdata = wd; c_mask = m;
      seen_c_ready = 0;
      for (int k = 0; k < 20 && !seen_c_ready; k++) tick();
      check_eq("c_accept", seen_c_ready, 1);
      c_req_valid = 0;
   endtask

   task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] m);
      d_req_valid = 1; d_we = we; d_addr = a; d_wdata = wd; d_mask = m;
      seen_d_ready = 0;
      for (int k = 0; k < 20 && !seen_d_ready; k++) tick();
      check_eq("d_accept", seen_d_ready, 1);
      d_req_valid = 0;
   endtask

   // Issue on C, then take the following cycle and compare the single response.
   task automatic c_req_check(input string tag, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [2:0] m,
                              input logic [31:0] exp_rdata, input logic exp_err);
      int n0;
      issue_c(we, a, wd, m);
      n0 = c_rsp_cnt;
      tick();
      check_eq({tag, "_rsp_cnt"}, c_rsp_cnt - n0, 1);
      check_eq({tag, "_rdata"}, last_c_rdata, exp_rdata);
      check_eq({tag, "_err"}, last_c_err, exp_err);
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) return 32'h1000 + 32'($urandom_range(0, 255));
      if (r == 1) return 32'hFFC + 32'($urandom_range(0, 3));
      return 32'($urandom_range(0, 127));
   endfunction

   function automatic logic [2:0] rand_mask();
      logic [2:0] legal_set [5];
      legal_set = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU};
      if ($urandom_range(0, 3) != 0) return legal_set[$urandom_range(0, 4)];
      return 3'($urandom_range(0, 7));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int n0, bad;
      for (int i = 0; i < MEM_BYTES; i++) begin
         phys[i]    = 8'($urandom);
         ref_mem[i] = phys[i];
      end

      // Reset with both requesters active
      rst = 1;
      c_req_valid = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'h1234_5678; c_mask = MASK_W;
      d_req_valid = 1; d_we = 1; d_addr = 32'h14; d_wdata = 32'h9ABC_DEF0; d_mask = MASK_W;
      we_seen = 0;
      repeat (3) tick();
      check_eq("reset_no_we", we_seen, 0);
      rst = 0;
      idle(2);

      // Store word then loads of varying width
      issue_c(1, 32'h10, 32'hDEAD_BEEF, MASK_W);
      c_req_check("ld_w", 0, 32'h10, 0, MASK_W, 32'hDEAD_BEEF, 0);
      c_req_check("ld_b", 0, 32'h10, 0, MASK_B, 32'hFFFF_FFEF, 0);
      c_req_check("ld_bu", 0, 32'h10, 0, MASK_BU, 32'h0000_00EF, 0);

      // Contention: D must win every fifth cycle
      idle(1);
      c_req_valid = 1; c_we = 0; c_addr = 32'h10; c_mask = MASK_W;
      d_req_valid = 1; d_we = 0; d_addr = 32'h14; d_mask = MASK_W;
      for (int i = 0; i < 15; i++) begin
         tick();
         check_eq("contention_d_grant", seen_d_ready, (i % 5) == 4);
         check_eq("contention_c_grant", seen_c_ready, (i % 5) != 4);
      end
      idle(2);

      // Illegal requests are accepted with an error and never write
      we_seen = 0;
      c_req_check("st_h_mis", 1, 32'h13, 32'h0000_5555, MASK_H, 0, 1);
      c_req_check("ld_w_mis", 0, 32'h12, 0, MASK_W, 0, 1);
      c_req_check("st_bu", 1, 32'h18, 32'h77, MASK_BU, 0, 1);
      c_req_check("ld_oor", 0, 32'h1000, 0, MASK_W, 0, 1);
      check_eq("illegal_no_we", we_seen, 0);
      c_req_check("ld_w_after_ill", 0, 32'h10, 0, MASK_W, 32'hDEAD_BEEF, 0);

      // Back-to-back across ports
      n0 = d_rsp_cnt;
      issue_d(1, 32'h21, 32'h0000_00AB, MASK_B);
      issue_c(0, 32'h20, 0, MASK_HU);
      check_eq("b2b_d_rsp_cnt", d_rsp_cnt - n0, 1);
      check_eq("b2b_d_err", last_d_err, 0);
      n0 = c_rsp_cnt;
      tick();
      check_eq("b2b_c_rsp_cnt", c_rsp_cnt - n0, 1);
      check_eq("b2b_c_hi", last_c_rdata[15:8], 8'hAB);
      check_eq("b2b_c_top", last_c_rdata[31:16], 16'h0);

      // Reset right after an accept drops the response
      c_req_valid = 1; c_we = 0; c_addr = 32'h10; c_mask = MASK_W;
      tick();
      check_eq("rst_mid_accept", seen_c_ready, 1);
      c_req_valid = 0;
      rst = 1;
      n0 = c_rsp_cnt;
      tick();
      rst = 0;
      tick();
      tick();
      check_eq("rst_mid_no_rsp", c_rsp_cnt - n0, 0);
      c_req_check("post_rst_ld", 0, 32'h10, 0, MASK_W, 32'hDEAD_BEEF, 0);

      // Randomized traffic against the model
      seen_c_ready = 0;
      seen_d_ready = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 249) == 0);
         if (!c_req_valid || seen_c_ready) begin
            c_req_valid = ($urandom_range(0, 3) != 0);
            c_we = 1'($urandom_range(0, 1)); c_addr = rand_addr();
            c_wdata = $urandom; c_mask = rand_mask();
         end
         if (!d_req_valid || seen_d_ready) begin
            d_req_valid = ($urandom_range(0, 1) != 0);
            d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
            d_wdata = $urandom; d_mask = rand_mask();
         end
         tick();
      end
      rst = 0;
      idle(3);

      bad = 0;
      for (int i = 0; i < MEM_BYTES; i++) if (phys[i] !== ref_mem[i]) bad++;
      check_eq("mem_final", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
